serial_add_sequencer: RTL and testbench

Bit-serial adder controller. It accepts one pair of WIDTH-bit operands plus a carry-in, then drives a single full_adder instance (built from two half_adder instances) one bit per clock, LSB first, with a registered carry. The finished sum and carry-out are presented on a valid/ready result port. It lets one adder cell be shared across operand widths, replacing a WIDTH-cell ripple chain.

---
 rtl/serial_add_sequencer.sv | 99 +++++++++
 tb/tb_serial_add_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: bit-serial adder sharing one full_adder cell, LSB first, with a valid/ready result port.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0, c0, c1;
  half_adder u_h0 (.x(x), .y(y), .s(s0), .c(c0));
  half_adder u_h1 (.x(s0), .y(ci), .s(s), .c(c1));
  assign co = c0 | c1;
endmodule

module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, ps, ps_nx;
  logic [CW-1:0] cnt;
  logic c_reg, fa_s, fa_c, last;
  full_adder u_fa (.x(a_sh[0]), .y(b_sh[0]), .ci(c_reg), .s(fa_s), .co(fa_c));
  assign last = cnt == LAST;
  generate
    if (WIDTH == 1) begin : g_one
      assign ps_nx = fa_s;
    end else begin : g_many
      assign ps_nx = {fa_s, ps[WIDTH-1:1]};
    end
  endgenerate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state == IDLE ? (start_valid ? RUN : IDLE)
             : state == RUN  ? (last ? DONE : RUN)
             : (result_ready ? IDLE : DONE);
  end
  always_comb begin
    start_ready  = state == IDLE;
    result_valid = state == DONE;
    busy         = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      ps        <= '0;
      cnt       <= '0;
      c_reg     <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else if (state == IDLE && start_valid) begin
      a_sh  <= a;
      b_sh  <= b;
      c_reg <= carry_in;
      cnt   <= '0;
      ps    <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      c_reg <= fa_c;
      ps    <= ps_nx;
      // hold at the last bit index so the counter never wraps
      cnt   <= last ? cnt : cnt + CW'(1);
      if (last) begin
        sum       <= ps_nx;
        carry_out <= fa_c;
      end
    end
  end
endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb_serial_add_sequencer: scoreboard bench for the 8-bit sequencer plus a WIDTH=1 instance.
module tb_serial_add_sequencer;
  logic clk, rst_n;
  logic sv, sr, ci, rv, rr, co, busy;
  logic [7:0] a, b, sum;
  logic sv1, sr1, a1, b1, c1, rv1, rr1, s1, co1, bz1;
  int cmps = 0, errs = 0, cyc = 0, hs_cyc = 0, last_acc = 0;
  logic [8:0] sb[$];
  int acc_q[$];
  logic prev_v = 1'b0;

  serial_add_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(sv), .start_ready(sr), .a(a), .b(b),
    .carry_in(ci), .result_valid(rv), .result_ready(rr), .sum(sum), .carry_out(co), .busy(busy));
  serial_add_sequencer #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(sr1), .a(a1), .b(b1),
    .carry_in(c1), .result_valid(rv1), .result_ready(rr1), .sum(s1), .carry_out(co1), .busy(bz1));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmps++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    cmps++;
    errs++;
    $display("FAIL %s: got timeout/unexpected expected event", nm);
  endtask

  task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic c, input logic [8:0] e);
    int n = 0;
    @(negedge clk);
    while (!sr && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail("accept_timeout");
    sv = 1'b1;
    a = x;
    b = y;
    ci = c;
    sb.push_back(e);
    acc_q.push_back(cyc + 1);
    last_acc = cyc + 1;
    @(posedge clk);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    sv = 1'b0;
    while ((sb.size() != 0 || !sr) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail("drain_timeout");
  endtask

  always begin
    @(negedge clk);
    #1;
    if (!rst_n) prev_v = 1'b0;
    else begin
      if (rv) begin
        if (!prev_v && acc_q.size() != 0) chk("latency", 64'(cyc - acc_q.pop_front()), 64'd8);
        if (sb.size() != 0) chk("hold", {co, sum}, sb[0]);
        chk("start_ready_in_done", sr, 0);
        chk("busy_in_done", busy, 1);
        if (rr) begin
          if (sb.size() != 0) begin
            chk("result", {co, sum}, sb.pop_front());
            hs_cyc = cyc + 1;
          end else fail("unexpected_result");
        end
      end
      prev_v = rv;
    end
  end

  initial begin
    int t, n;
    rst_n = 1'b0;
    sv = 0; a = 0; b = 0; ci = 0; rr = 1;
    sv1 = 0; a1 = 0; b1 = 0; c1 = 0; rr1 = 1;
    repeat (2) @(negedge clk);
    chk("rst_start_ready", sr, 1);
    chk("rst_result_valid", rv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum_co", {co, sum}, 0);
    chk("rst_w1_outputs", {sr1, rv1, bz1, s1, co1}, 5'b10000);
    rst_n = 1'b1;
    issue(8'h5A, 8'h3C, 0, 9'h096);
    @(negedge clk);
    chk("busy_in_run", {busy, sr}, 2'b10);
    drain();
    issue(8'hFF, 8'h01, 0, 9'h100);
    issue(8'hFF, 8'h00, 1, 9'h100);
    issue(8'h00, 8'h00, 0, 9'h000);
    drain();
    rr = 0;
    issue(8'h12, 8'h34, 0, 9'h046);
    n = 0;
    while (!rv && n < 50) begin
      @(negedge clk);
      a = a + 8'h11;
      b = b ^ 8'h5C;
      n++;
    end
    if (n >= 50) fail("bp_valid_timeout");
    repeat (5) begin
      @(negedge clk);
      a = a + 8'h07;
      b = b - 8'h03;
      chk("bp_sum", sum, 8'h46);
      chk("bp_valid_ready", {rv, sr}, 2'b10);
    end
    rr = 1;
    issue(8'h00, 8'h00, 0, 9'h000);
    chk("bp_accept_gap", 64'(last_acc - hs_cyc), 64'd1);
    drain();
    issue(8'h01, 8'h01, 0, 9'h002);
    t = last_acc;
    issue(8'h80, 8'h80, 0, 9'h100);
    chk("b2b_gap", 64'(last_acc - t), 64'd10);
    drain();
    issue(8'hAA, 8'h55, 0, 9'h0FF);
    @(negedge clk);
    sv = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {rv, busy, sr}, 3'b001);
    chk("abort_sum_co", {co, sum}, 0);
    sb.delete();
    acc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_reset_ready", sr, 1);
    issue(8'h03, 8'h04, 0, 9'h007);
    drain();
    @(negedge clk);
    sv1 = 1; a1 = 1; b1 = 1; c1 = 1; rr1 = 0;
    @(negedge clk);
    sv1 = 0;
    chk("w1_run", {rv1, bz1}, 2'b01);
    @(negedge clk);
    chk("w1_done", {rv1, co1, s1}, 3'b111);
    rr1 = 1;
    @(negedge clk);
    chk("w1_idle_hold", {sr1, rv1, co1, s1}, 4'b1011);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
